// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchronizer, hold-time qualification FSM,
// registered debounced level, one-cycle press/release strobes and a wrapping press count.
module btn_debounce_pulse #(
    parameter int unsigned CNT_MAX = 999_999,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_db,
    output logic       btn_pulse,
    output logic       btn_rel,
    output logic [7:0] press_cnt
);

    localparam int unsigned      PCNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HI,
        HIGH,
        WAIT_LO
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s1_q, s2_q;
    logic              db_q, db_d;
    logic              pulse_q, pulse_d;
    logic              rel_q, rel_d;
    logic [PCNT_W-1:0] press_q, press_d;

    // Two-flop synchronizer; nothing downstream looks at btn_in directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
            rel_q   <= 1'b0;
            press_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            pulse_q <= pulse_d;
            rel_q   <= rel_d;
            press_q <= press_d;
        end
    end

    // A new level is accepted only after s2 holds it for CNT_MAX+2 consecutive samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        pulse_d = 1'b0;
        rel_d   = 1'b0;
        press_d = press_q;
        case (state_q)
            LOW: begin
                if (s2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s2_q) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    pulse_d = 1'b1;
                    press_d = press_q + PCNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s2_q) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_db    = db_q;
    assign btn_pulse = pulse_q;
    assign btn_rel   = rel_q;
    assign press_cnt = press_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Randomized and directed bench for btn_debounce_pulse against a run-length reference model.
module tb_btn_debounce_pulse;

    localparam int unsigned CNT_MAX = 3;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned QUAL    = CNT_MAX + 2;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       btn_db;
    logic       btn_pulse;
    logic       btn_rel;
    logic [7:0] press_cnt;

    int unsigned n_checks;
    int unsigned n_passed;

    btn_debounce_pulse #(
        .CNT_MAX(CNT_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_db   (btn_db),
        .btn_pulse(btn_pulse),
        .btn_rel  (btn_rel),
        .press_cnt(press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the FSM sees btn_in two edges late; the level flips once the
    // delayed input has disagreed with it for QUAL consecutive edges.
    bit          dly[$];
    bit          m_seen;
    int unsigned run;
    logic        m_db;
    logic        m_pulse;
    logic        m_rel;
    logic [7:0]  m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            dly.delete();
            dly.push_back(1'b0);
            dly.push_back(1'b0);
            run     = 0;
            m_db    = 1'b0;
            m_pulse = 1'b0;
            m_rel   = 1'b0;
            m_cnt   = 8'd0;
        end else begin
            m_seen = dly.pop_front();
            dly.push_back(btn_in);
            m_pulse = 1'b0;
            m_rel   = 1'b0;
            if (m_seen != m_db) begin
                run++;
                if (run == QUAL) begin
                    run  = 0;
                    m_db = m_seen;
                    if (m_seen) begin
                        m_pulse = 1'b1;
                        m_cnt   = m_cnt + 8'd1;
                    end else begin
                        m_rel = 1'b1;
                    end
                end
            end else begin
                run = 0;
            end
        end
    end

    function automatic logic [10:0] obs();
        return {btn_db, btn_pulse, btn_rel, press_cnt};
    endfunction

    function automatic logic [10:0] expv();
        return {m_db, m_pulse, m_rel, m_cnt};
    endfunction

    task automatic tick(input logic b);
        btn_in = b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(logic'(k % 2));
            n_checks++;
            if (obs() !== 11'd0 || dut.s2_q !== 1'b0)
                $display("FAIL reset cyc=%0d got=%b s2=%b exp=%b s2=0", k, obs(), dut.s2_q, 11'd0);
            else n_passed++;
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL reset_idle cyc=%0d got=%b exp=%b", k, obs(), expv());
            else n_passed++;
        end
    endtask

    task automatic test_clean_press();
        int unsigned np;
        logic [10:0] want;
        np = 0;
        for (int k = 0; k < 58; k++) begin
            tick(1'b1);
            np += int'(btn_pulse);
            n_checks++;
            if (obs() !== expv()) $display("FAIL press_model cyc=%0d got=%b exp=%b", k, obs(), expv());
            else n_passed++;
            if (k >= 5 && k <= 7) begin
                want = {logic'(k >= 6), logic'(k == 6), 1'b0, (k >= 6) ? 8'd1 : 8'd0};
                n_checks++;
                if (obs() !== want) $display("FAIL press_latency E%0d got=%b exp=%b", k, obs(), want);
                else n_passed++;
            end
        end
        n_checks++;
        if (np !== 1 || press_cnt !== 8'd1) $display("FAIL press_held pulses=%0d cnt=%0d exp 1/1", np, press_cnt);
        else n_passed++;
    endtask

    task automatic test_release();
        int unsigned nr;
        logic [10:0] want;
        nr = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0);
            nr += int'(btn_rel);
            n_checks++;
            if (obs() !== expv()) $display("FAIL release_model cyc=%0d got=%b exp=%b", k, obs(), expv());
            else n_passed++;
            if (k >= 5) begin
                want = {logic'(k < 6), 1'b0, logic'(k == 6), 8'd1};
                n_checks++;
                if (obs() !== want) $display("FAIL release_latency R%0d got=%b exp=%b", k, obs(), want);
                else n_passed++;
            end
        end
        for (int k = 0; k < 10; k++) tick(1'b1);
        nr = 0;
        for (int k = 0; k < 15; k++) begin
            tick(k < 3 ? 1'b0 : 1'b1);
            nr += int'(btn_rel);
            n_checks++;
            if (obs() !== expv()) $display("FAIL glitch_model cyc=%0d got=%b exp=%b", k, obs(), expv());
            else n_passed++;
        end
        n_checks++;
        if (nr !== 0 || btn_db !== 1'b1) $display("FAIL release_glitch rel=%0d db=%b exp 0/1", nr, btn_db);
        else n_passed++;
        for (int k = 0; k < 10; k++) tick(1'b0);
    endtask

    task automatic test_bounce();
        int unsigned lvl[5] = '{1, 0, 1, 0, 1};
        int unsigned len[5] = '{3, 2, 4, 10, 20};
        logic [7:0]  base;
        int unsigned np;
        base = m_cnt;
        np   = 0;
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < int'(len[s]); k++) begin
                tick(logic'(lvl[s]));
                np += int'(btn_pulse);
                n_checks++;
                if (obs() !== expv()) $display("FAIL bounce_model seg=%0d cyc=%0d got=%b exp=%b", s, k, obs(), expv());
                else n_passed++;
                if (s < 4) begin
                    n_checks++;
                    if (btn_db !== 1'b0 || press_cnt !== base)
                        $display("FAIL bounce_reject seg=%0d db=%b cnt=%0d exp 0/%0d", s, btn_db, press_cnt, base);
                    else n_passed++;
                end
            end
        end
        n_checks++;
        if (np !== 1) $display("FAIL bounce_accept pulses=%0d exp 1", np);
        else n_passed++;
        for (int k = 0; k < 10; k++) tick(1'b0);
    endtask

    task automatic test_wrap();
        logic [7:0]  base;
        int unsigned np;
        int unsigned nr;
        base = m_cnt;
        np   = 0;
        nr   = 0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 20; k++) begin
                tick(k < 10 ? 1'b1 : 1'b0);
                np += int'(btn_pulse);
                nr += int'(btn_rel);
                n_checks++;
                if (obs() !== expv()) $display("FAIL wrap_model iter=%0d cyc=%0d got=%b exp=%b", i, k, obs(), expv());
                else n_passed++;
                if (k == 9) begin
                    n_checks++;
                    if (press_cnt !== 8'(int'(base) + i + 1))
                        $display("FAIL wrap_count iter=%0d got=%0d exp=%0d", i, press_cnt, 8'(int'(base) + i + 1));
                    else n_passed++;
                end
            end
        end
        n_checks++;
        if (np !== 256 || nr !== 256 || press_cnt !== base)
            $display("FAIL wrap_total pulses=%0d rels=%0d cnt=%0d exp 256/256/%0d", np, nr, press_cnt, base);
        else n_passed++;
    endtask

    task automatic test_random();
        logic lvl;
        int   len;
        lvl = 1'b0;
        for (int s = 0; s < 80; s++) begin
            lvl = ~lvl;
            len = int'($urandom_range(1, 9));
            for (int k = 0; k < len; k++) begin
                tick(lvl);
                n_checks++;
                if (obs() !== expv() || int'(dut.cnt_q) > int'(CNT_MAX) || (btn_pulse && btn_rel))
                    $display("FAIL random seg=%0d cyc=%0d got=%b exp=%b cnt=%0d", s, k, obs(), expv(), dut.cnt_q);
                else n_passed++;
            end
        end
        for (int k = 0; k < 10; k++) tick(1'b0);
    endtask

    task automatic test_reset_mid();
        logic [10:0] want;
        for (int k = 0; k < 5; k++) tick(1'b1);
        n_checks++;
        if (dut.cnt_q !== CNT_W'(2)) $display("FAIL midq_setup cnt=%0d exp 2", dut.cnt_q);
        else n_passed++;
        rst = 1'b1;
        tick(1'b1);
        n_checks++;
        if (obs() !== 11'd0) $display("FAIL midq_reset got=%b exp=%b", obs(), 11'd0);
        else n_passed++;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b1);
            want = {logic'(k >= 6), logic'(k == 6), 1'b0, (k >= 6) ? 8'd1 : 8'd0};
            n_checks++;
            if (obs() !== want || obs() !== expv())
                $display("FAIL midq_repress E%0d got=%b exp=%b model=%b", k, obs(), want, expv());
            else n_passed++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        rst      = 1'b1;
        btn_in   = 1'b0;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
